// File: rtl/command_issue_gate.sv
// Command FIFO that issues PSL commands one at a time under credit control.
// It stamps each issued command with a wrapping tag and counts the cycles it spends stalled.
module command_issue_gate #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [12:0]              enq_command,
  input  logic [63:0]              enq_address,
  input  logic [11:0]              enq_size,
  input  logic [7:0]               credits,
  output logic                     cmd_valid,
  output logic [12:0]              cmd_command,
  output logic [63:0]              cmd_address,
  output logic [11:0]              cmd_size,
  output logic [TAG_W-1:0]         cmd_tag,
  output logic                     valid_request,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              stall_cycles
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  logic [12:0] cmd_mem  [DEPTH];
  logic [63:0] addr_mem [DEPTH];
  logic [11:0] size_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic             cmd_valid_q;
  logic [12:0]      cmd_command_q;
  logic [63:0]      cmd_address_q;
  logic [11:0]      cmd_size_q;
  logic [TAG_W-1:0] cmd_tag_q, tag_ctr_q;
  logic [31:0]      stall_q, stall_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // No pass-through: a full FIFO refuses the push even in a cycle that pops.
  assign enq_ready = reset | ~full;
  assign push      = enq_valid & ~full;
  // The only command in flight is the one on cmd_valid; credits lag it by a cycle.
  assign pop       = ~empty & enable & (credits > {7'b0, cmd_valid_q});

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = STALL;
    if (count_d == '0)
      state_d = IDLE;
    else if (enable && (credits > {7'b0, pop}))
      state_d = ISSUE;
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q == STALL && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      cmd_mem[wr_ptr_q]  <= enq_command;
      addr_mem[wr_ptr_q] <= enq_address;
      size_mem[wr_ptr_q] <= enq_size;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      cmd_valid_q   <= 1'b0;
      cmd_command_q <= '0;
      cmd_address_q <= '0;
      cmd_size_q    <= '0;
      cmd_tag_q     <= '0;
      tag_ctr_q     <= '0;
      stall_q       <= '0;
    end else begin
      count_q     <= count_d;
      state_q     <= state_d;
      stall_q     <= stall_d;
      cmd_valid_q <= pop;
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + PW'(1);
        cmd_command_q <= cmd_mem[rd_ptr_q];
        cmd_address_q <= addr_mem[rd_ptr_q];
        cmd_size_q    <= size_mem[rd_ptr_q];
        cmd_tag_q     <= tag_ctr_q;
        tag_ctr_q     <= tag_ctr_q + TAG_W'(1);
      end
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign valid_request = cmd_valid_q;
  assign cmd_command   = cmd_command_q;
  assign cmd_address   = cmd_address_q;
  assign cmd_size      = cmd_size_q;
  assign cmd_tag       = cmd_tag_q;
  assign fifo_count    = count_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_command_issue_gate.sv
// Directed bench for command_issue_gate: a cycle table for credit/stall/order behaviour,
// plus hand-written sequences for reset, tag wrap and reset during issue.
module tb_command_issue_gate;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        enq_valid;
  logic        enq_ready;
  logic [12:0] enq_command;
  logic [63:0] enq_address;
  logic [11:0] enq_size;
  logic [7:0]  credits;
  logic        cmd_valid;
  logic [12:0] cmd_command;
  logic [63:0] cmd_address;
  logic [11:0] cmd_size;
  logic [7:0]  cmd_tag;
  logic        valid_request;
  logic [3:0]  fifo_count;
  logic [31:0] stall_cycles;

  command_issue_gate #(.DEPTH(8), .TAG_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_command(enq_command), .enq_address(enq_address), .enq_size(enq_size),
    .credits(credits),
    .cmd_valid(cmd_valid), .cmd_command(cmd_command), .cmd_address(cmd_address),
    .cmd_size(cmd_size), .cmd_tag(cmd_tag), .valid_request(valid_request),
    .fifo_count(fifo_count), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          en;
    bit          ev;
    int unsigned id;
    logic [7:0]  cred;
    bit          cv;
    int unsigned tag;
    int unsigned xid;
    int unsigned cnt;
    bit          rdy;
    int          inc;
  } vec_t;

  vec_t        tbl[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [12:0] e_cmd;
  logic [63:0] e_addr;
  logic [11:0] e_size;

  function automatic logic [12:0] f_cmd(int unsigned id);
    return 13'(id);
  endfunction
  function automatic logic [63:0] f_addr(int unsigned id);
    return 64'hA5A5_0000_0000_0000 | (64'(id) << 8);
  endfunction
  function automatic logic [11:0] f_size(int unsigned id);
    return 12'(id + 16);
  endfunction

  function automatic void add(bit rst, bit en, bit ev, int unsigned id, logic [7:0] cred,
                              bit cv, int unsigned tag, int unsigned xid, int unsigned cnt,
                              bit rdy, int inc);
    vec_t v;
    v.rst = rst; v.en = en; v.ev = ev; v.id = id; v.cred = cred;
    v.cv = cv; v.tag = tag; v.xid = xid; v.cnt = cnt; v.rdy = rdy; v.inc = inc;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input bit ev, input int unsigned id, input logic [7:0] cred);
    enable      = en;
    enq_valid   = ev;
    enq_command = f_cmd(id);
    enq_address = f_addr(id);
    enq_size    = f_size(id);
    credits     = cred;
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    enq_valid = 1'b0;
    #3;
    reset     = 1'b0;
    e_cmd = '0; e_addr = '0; e_size = '0;
  endtask

  task automatic check_zero(input string tagname);
    check({tagname, "_cv"},    64'(cmd_valid), 64'd0);
    check({tagname, "_vr"},    64'(valid_request), 64'd0);
    check({tagname, "_cmd"},   64'(cmd_command), 64'd0);
    check({tagname, "_addr"},  cmd_address, 64'd0);
    check({tagname, "_size"},  64'(cmd_size), 64'd0);
    check({tagname, "_tag"},   64'(cmd_tag), 64'd0);
    check({tagname, "_cnt"},   64'(fifo_count), 64'd0);
    check({tagname, "_stall"}, stall_cycles, 64'd0);
    check({tagname, "_rdy"},   64'(enq_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_issue;
    logic [31:0] prev;

    // Stalled with zero credits, then single-credit trickle where inflight blocks.
    add(0,1,1,1,0,  0,0,0,1,1,-1);
    add(0,1,1,2,0,  0,0,0,2,1, 1);
    add(0,1,1,3,0,  0,0,0,3,1, 1);
    add(0,1,0,0,0,  0,0,0,3,1, 1);
    add(0,1,0,0,1,  1,0,1,2,1,-1);
    add(0,1,0,0,1,  0,0,0,2,1,-1);
    add(0,1,0,0,1,  1,1,2,1,1,-1);
    add(0,1,0,0,1,  0,0,0,1,1,-1);
    add(0,1,0,0,2,  1,2,3,0,1,-1);
    add(0,1,0,0,2,  0,0,0,0,1, 0);
    // Fill to full with enable low, then stream out back-to-back with a push at full.
    add(1,0,1,16,64, 0,0,0,1,1,-1);
    for (int unsigned k = 1; k < 7; k++)
      add(0,0,1,16+k,64, 0,0,0,1+k,1,1);
    add(0,0,1,23,64, 0,0,0,8,0,1);
    add(0,1,1,24,64, 1,0,16,7,1,-1);
    add(0,1,1,24,64, 1,1,17,7,1,-1);
    for (int unsigned k = 0; k < 6; k++)
      add(0,1,0,0,64, 1,2+k,18+k,6-k,1,-1);
    add(0,1,0,0,64, 1,8,24,0,1,-1);
    add(0,1,0,0,64, 0,0,0,0,1,-1);

    reset = 1'b1;
    drive(1'b0, 1'b1, 99, 8'd0);
    e_cmd = '0; e_addr = '0; e_size = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    check("reset_no_push", 64'(fifo_count), 64'd0);
    reset     = 1'b0;
    enq_valid = 1'b0;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      if (v.rst) pulse_reset();
      drive(v.en, v.ev, v.id, v.cred);
      prev = stall_cycles;
      @(posedge clock);
      #1;
      if (v.cv) begin
        e_cmd = f_cmd(v.xid); e_addr = f_addr(v.xid); e_size = f_size(v.xid);
        check($sformatf("row%0d_tag", i), 64'(cmd_tag), 64'(v.tag));
      end
      check($sformatf("row%0d_cv", i),   64'(cmd_valid), 64'(v.cv));
      check($sformatf("row%0d_vr", i),   64'(valid_request), 64'(v.cv));
      check($sformatf("row%0d_cnt", i),  64'(fifo_count), 64'(v.cnt));
      check($sformatf("row%0d_rdy", i),  64'(enq_ready), 64'(v.rdy));
      check($sformatf("row%0d_cmd", i),  64'(cmd_command), 64'(e_cmd));
      check($sformatf("row%0d_addr", i), cmd_address, e_addr);
      check($sformatf("row%0d_size", i), 64'(cmd_size), 64'(e_size));
      if (v.inc >= 0)
        check($sformatf("row%0d_stall_inc", i), 64'(stall_cycles - prev), 64'(v.inc));
    end

    // Continuous push/pop stream: tags must count 0..255 then wrap to 0.
    pulse_reset();
    n_issue = 0;
    for (int unsigned c = 0; c < 300; c++) begin
      drive(1'b1, 1'b1, c, 8'd64);
      @(posedge clock);
      #1;
      if (cmd_valid) begin
        check("wrap_tag", 64'(cmd_tag), 64'(n_issue % 256));
        check("wrap_order", 64'(cmd_command), 64'(f_cmd(n_issue)));
        n_issue++;
      end
    end
    check("wrap_issue_count", 64'(n_issue), 64'd299);

    // Reset arriving mid-cycle while a command is on the outputs and 5 remain queued.
    pulse_reset();
    for (int unsigned k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 40 + k, 8'd64);
      @(posedge clock);
      #1;
    end
    drive(1'b1, 1'b0, 0, 8'd64);
    @(posedge clock);
    #1;
    check("mid_cv", 64'(cmd_valid), 64'd1);
    check("mid_cmd", 64'(cmd_command), 64'(f_cmd(40)));
    check("mid_cnt", 64'(fifo_count), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async");
    #2;
    reset = 1'b0;
    for (int unsigned c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      check("post_reset_cv", 64'(cmd_valid), 64'd0);
      check("post_reset_cnt", 64'(fifo_count), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
